// File: rtl/serdesphy_pcs_pkg.sv
// Shared PCS definitions for the 4b5b RX decoder/aligner and the TX encoder.
// Holds the 4b5b data code table, the IDLE/J/K control codes, the 10-bit JK
// sync pattern used for symbol framing, and the alignment state encodings.
package serdesphy_pcs_pkg;

    localparam int SYM_W = 5;

    localparam logic [4:0] SYM_IDLE = 5'b11111;
    localparam logic [4:0] SYM_J    = 5'b11000;
    localparam logic [4:0] SYM_K    = 5'b10001;

    // J followed by K, MSB of J transmitted first.
    localparam logic [9:0] SYNC_JK = {SYM_J, SYM_K};

    // Indexed by nibble value; element 0 is the rightmost entry.
    localparam logic [15:0][4:0] DATA_CODES = {
        5'b11101, 5'b11100, 5'b11011, 5'b11010,   // F E D C
        5'b10111, 5'b10110, 5'b10011, 5'b10010,   // B A 9 8
        5'b01111, 5'b01110, 5'b01011, 5'b01010,   // 7 6 5 4
        5'b10101, 5'b10100, 5'b01001, 5'b11110    // 3 2 1 0
    };

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } align_state_e;

    function automatic logic [4:0] enc_4b5b(input logic [3:0] nib);
        return DATA_CODES[nib];
    endfunction

endpackage

// File: rtl/serdesphy_4b5b_dec.sv
// Combinational 4b5b symbol decoder.
// Ports:
//   code       - 5-bit received symbol, MSB first on the wire
//   nibble     - decoded data value (0 when not a data symbol)
//   is_data    - code is one of the 16 data symbols
//   is_idle    - code is IDLE
//   is_j/is_k  - code is the J / K sync symbol
//   is_invalid - code matches none of the above
module serdesphy_4b5b_dec
    import serdesphy_pcs_pkg::*;
(
    input  logic [4:0] code,
    output logic [3:0] nibble,
    output logic       is_data,
    output logic       is_idle,
    output logic       is_j,
    output logic       is_k,
    output logic       is_invalid
);

    always_comb begin
        nibble  = 4'd0;
        is_data = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (code == DATA_CODES[i]) begin
                nibble  = 4'(i);
                is_data = 1'b1;
            end
        end
        is_idle    = (code == SYM_IDLE);
        is_j       = (code == SYM_J);
        is_k       = (code == SYM_K);
        is_invalid = ~(is_data | is_idle | is_j | is_k);
    end

endmodule

// File: rtl/serdesphy_rx_align_dec.sv
// RX PCS symbol aligner and 4b5b decoder.
// Hunts for the J/K sync pair in the serial bit stream, verifies framing over
// VERIFY_SYMS clean symbols, then decodes symbols into nibbles while locked.
// Ports:
//   clk_240m_rx / rst_n_240m_rx - RX clock, synchronous active-low reset
//   rx_en, rx_align_rst         - enable; level re-hunt + error counter clear
//   rx_serial_data/valid/error  - serial bit in, qualifier, per-bit error flag
//   rx_data, rx_valid           - decoded nibble and its one-cycle strobe
//   rx_aligned, align_state     - lock indication and framing state
//   rx_error, rx_idle_det       - one-cycle strobes for invalid / IDLE symbols
//   rx_sym_err_cnt              - saturating invalid-symbol counter
module serdesphy_rx_align_dec
    import serdesphy_pcs_pkg::*;
#(
    parameter int VERIFY_SYMS = 4,
    parameter int LOSS_SYMS   = 4,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk_240m_rx,
    input  logic                 rst_n_240m_rx,
    input  logic                 rx_en,
    input  logic                 rx_align_rst,
    input  logic                 rx_serial_data,
    input  logic                 rx_serial_valid,
    input  logic                 rx_serial_error,
    output logic [3:0]           rx_data,
    output logic                 rx_valid,
    output logic                 rx_aligned,
    output logic                 rx_error,
    output logic                 rx_idle_det,
    output logic [ERR_CNT_W-1:0] rx_sym_err_cnt,
    output logic [1:0]           align_state
);

    localparam logic [2:0]           PHASE_LAST  = 3'd4;
    localparam logic [3:0]           VERIFY_LAST = 4'(VERIFY_SYMS - 1);
    localparam logic [3:0]           LOSS_LAST   = 4'(LOSS_SYMS - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX     = '1;

    align_state_e         state_q, state_d;
    logic [9:0]           win_q, win_d;
    logic [2:0]           phase_q, phase_d;
    logic [3:0]           vcnt_q, vcnt_d;
    logic [3:0]           loss_q, loss_d;
    logic                 sym_err_q, sym_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [3:0]           data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 error_q, error_d;
    logic                 idle_q, idle_d;
    logic                 aligned_q, aligned_d;

    logic [9:0] win_shift;
    logic [3:0] dec_nibble;
    logic       dec_is_data, dec_is_idle, dec_is_j, dec_is_k, dec_is_invalid;
    logic       sym_err_any, sym_good, sym_bad;

    // The symbol being completed is the low 5 bits of the window including
    // the bit arriving this cycle.
    assign win_shift = {win_q[8:0], rx_serial_data};

    serdesphy_4b5b_dec u_dec (
        .code       (win_shift[4:0]),
        .nibble     (dec_nibble),
        .is_data    (dec_is_data),
        .is_idle    (dec_is_idle),
        .is_j       (dec_is_j),
        .is_k       (dec_is_k),
        .is_invalid (dec_is_invalid)
    );

    // An error flagged on any bit of the symbol spoils the whole symbol.
    assign sym_err_any = sym_err_q | rx_serial_error;
    assign sym_good    = (dec_is_data | dec_is_idle | dec_is_j | dec_is_k) & ~sym_err_any;
    assign sym_bad     = dec_is_invalid | sym_err_any;

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        phase_d   = phase_q;
        vcnt_d    = vcnt_q;
        loss_d    = loss_q;
        sym_err_d = sym_err_q;
        err_cnt_d = err_cnt_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        error_d   = 1'b0;
        idle_d    = 1'b0;

        if (rx_serial_valid) begin
            win_d = win_shift;
        end

        if (rx_align_rst || !rx_en) begin
            state_d   = ST_HUNT;
            phase_d   = '0;
            vcnt_d    = '0;
            loss_d    = '0;
            sym_err_d = 1'b0;
            if (rx_align_rst) begin
                err_cnt_d = '0;
            end
        end else if (rx_serial_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (win_shift == SYNC_JK) begin
                        state_d   = ST_VERIFY;
                        phase_d   = '0;
                        vcnt_d    = '0;
                        sym_err_d = 1'b0;
                    end
                end
                default: begin
                    if (phase_q != PHASE_LAST) begin
                        phase_d   = phase_q + 3'(1);
                        sym_err_d = sym_err_any;
                    end else begin
                        phase_d   = '0;
                        sym_err_d = 1'b0;
                        if (sym_bad && err_cnt_q != ERR_MAX) begin
                            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                        end
                        if (state_q == ST_VERIFY) begin
                            if (!sym_good) begin
                                state_d = ST_HUNT;
                                vcnt_d  = '0;
                            end else if (vcnt_q == VERIFY_LAST) begin
                                state_d = ST_LOCKED;
                                vcnt_d  = '0;
                                loss_d  = '0;
                            end else begin
                                vcnt_d = vcnt_q + 4'(1);
                            end
                        end else begin
                            if (!sym_good) begin
                                // The loss-triggering symbol gets no strobe since
                                // the block is leaving LOCKED on this edge.
                                if (loss_q == LOSS_LAST) begin
                                    state_d = ST_HUNT;
                                    loss_d  = '0;
                                end else begin
                                    loss_d  = loss_q + 4'(1);
                                    error_d = 1'b1;
                                end
                            end else begin
                                loss_d  = '0;
                                valid_d = dec_is_data;
                                idle_d  = dec_is_idle;
                                if (dec_is_data) begin
                                    data_d = dec_nibble;
                                end
                            end
                        end
                    end
                end
            endcase
        end

        aligned_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk_240m_rx) begin
        if (!rst_n_240m_rx) begin
            state_q   <= ST_HUNT;
            win_q     <= '0;
            phase_q   <= '0;
            vcnt_q    <= '0;
            loss_q    <= '0;
            sym_err_q <= 1'b0;
            err_cnt_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
            idle_q    <= 1'b0;
            aligned_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            phase_q   <= phase_d;
            vcnt_q    <= vcnt_d;
            loss_q    <= loss_d;
            sym_err_q <= sym_err_d;
            err_cnt_q <= err_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
            idle_q    <= idle_d;
            aligned_q <= aligned_d;
        end
    end

    assign rx_data        = data_q;
    assign rx_valid       = valid_q;
    assign rx_error       = error_q;
    assign rx_idle_det    = idle_q;
    assign rx_aligned     = aligned_q;
    assign rx_sym_err_cnt = err_cnt_q;
    assign align_state    = state_q;

endmodule

// File: tb/tb_serdesphy_rx_align_dec.sv
module tb_serdesphy_rx_align_dec;

    localparam int VS = 4;
    localparam int LS = 4;
    localparam int EW = 8;

    logic clk = 1'b0;
    always #2 clk = ~clk;

    logic          rst_n, rx_en, rx_align_rst, sd, sv, se;
    logic [3:0]    rx_data;
    logic          rx_valid, rx_aligned, rx_error, rx_idle_det;
    logic [EW-1:0] rx_sym_err_cnt;
    logic [1:0]    align_state;

    serdesphy_rx_align_dec #(.VERIFY_SYMS(VS), .LOSS_SYMS(LS), .ERR_CNT_W(EW)) dut (
        .clk_240m_rx     (clk),
        .rst_n_240m_rx   (rst_n),
        .rx_en           (rx_en),
        .rx_align_rst    (rx_align_rst),
        .rx_serial_data  (sd),
        .rx_serial_valid (sv),
        .rx_serial_error (se),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_aligned      (rx_aligned),
        .rx_error        (rx_error),
        .rx_idle_det     (rx_idle_det),
        .rx_sym_err_cnt  (rx_sym_err_cnt),
        .align_state     (align_state)
    );

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    // ---------------- behavioural model ----------------
    logic [4:0] data_tab [16] = '{5'b11110, 5'b01001, 5'b10100, 5'b10101,
                                  5'b01010, 5'b01011, 5'b01110, 5'b01111,
                                  5'b10010, 5'b10011, 5'b10110, 5'b10111,
                                  5'b11010, 5'b11011, 5'b11100, 5'b11101};

    int         m_state, m_bits, m_good, m_bad, m_cnt;
    logic [9:0] m_hist;
    logic [4:0] m_sym;
    logic       m_symerr;
    logic [3:0] m_data;
    logic       m_valid, m_err, m_idle;

    // 0 = data, 1 = idle, 2 = J/K, 3 = invalid
    function automatic int classify(input logic [4:0] c, output logic [3:0] nib);
        nib = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (c == data_tab[i]) begin
                nib = 4'(i);
                return 0;
            end
        end
        if (c == 5'b11111) return 1;
        if (c == 5'b11000 || c == 5'b10001) return 2;
        return 3;
    endfunction

    task automatic model_step();
        int         kind;
        logic [3:0] nib;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_idle  = 1'b0;
        if (sv) m_hist = {m_hist[8:0], sd};
        if (rx_align_rst || !rx_en) begin
            if (rx_align_rst) m_cnt = 0;
            m_state = 0; m_bits = 0; m_good = 0; m_bad = 0; m_symerr = 1'b0;
            return;
        end
        if (!sv) return;
        if (m_state == 0) begin
            if (m_hist == 10'b11000_10001) begin
                m_state = 1; m_bits = 0; m_good = 0; m_symerr = 1'b0;
            end
            return;
        end
        m_sym    = {m_sym[3:0], sd};
        m_symerr = m_symerr | se;
        m_bits   = m_bits + 1;
        if (m_bits < 5) return;
        m_bits = 0;
        kind   = classify(m_sym, nib);
        if (kind == 3 || m_symerr) begin
            if (m_cnt < 255) m_cnt = m_cnt + 1;
            if (m_state == 1) begin
                m_state = 0;
            end else begin
                m_bad = m_bad + 1;
                if (m_bad >= LS) begin
                    m_state = 0; m_bad = 0;
                end else begin
                    m_err = 1'b1;
                end
            end
        end else if (m_state == 1) begin
            m_good = m_good + 1;
            if (m_good >= VS) begin
                m_state = 2; m_bad = 0;
            end
        end else begin
            m_bad = 0;
            if (kind == 0) begin
                m_valid = 1'b1; m_data = nib;
            end else if (kind == 1) begin
                m_idle = 1'b1;
            end
        end
        m_symerr = m_symerr & 1'b0;
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_state = 0; m_bits = 0; m_good = 0; m_bad = 0; m_cnt = 0;
            m_hist = '0; m_sym = '0; m_symerr = 1'b0; m_data = '0;
            m_valid = 1'b0; m_err = 1'b0; m_idle = 1'b0;
        end else begin
            model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    int n_valid = 0, n_err = 0, n_idle = 0;
    logic [17:0] exp_v, act_v;

    always @(negedge clk) begin
        if (chk_en) begin
            exp_v = {m_data, m_valid, m_err, m_idle, (m_state == 2), m_cnt[7:0], 2'(m_state)};
            act_v = {rx_data, rx_valid, rx_error, rx_idle_det, rx_aligned, rx_sym_err_cnt, align_state};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL model_compare t=%0t actual=%h expected=%h", $time, act_v, exp_v);
            end
            if (rx_valid) n_valid++;
            if (rx_error) n_err++;
            if (rx_idle_det) n_idle++;
        end
    end

    task automatic check_lit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic send_bit(input logic b, input logic e = 1'b0);
        @(negedge clk);
        sd = b; sv = 1'b1; se = e;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            sv = 1'b0; se = 1'b0;
        end
    endtask

    task automatic send_sym(input logic [4:0] c, input int err_idx = -1);
        for (int i = 4; i >= 0; i--) send_bit(c[i], (4 - i) == err_idx);
    endtask

    task automatic send_jk();
        send_sym(5'b11000);
        send_sym(5'b10001);
    endtask

    int base;

    initial begin
        rst_n = 1'b0; rx_en = 1'b1; rx_align_rst = 1'b0; sd = 1'b0; sv = 1'b0; se = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check_lit("reset_state", align_state, 0);
        check_lit("reset_cnt", rx_sym_err_cnt, 0);
        check_lit("reset_aligned", rx_aligned, 0);
        check_lit("reset_data", rx_data, 0);
        rst_n = 1'b1;

        // idle stream, JK, verify on 4 IDLE
        repeat (3) send_sym(5'b11111);
        send_jk();
        gap(1);
        check_lit("jk_to_verify", align_state, 1);
        repeat (3) send_sym(5'b11111);
        repeat (4) send_bit(1'b1);
        gap(1);
        check_lit("pre_lock_aligned", rx_aligned, 0);
        send_bit(1'b1);
        gap(1);
        check_lit("lock_aligned", rx_aligned, 1);
        check_lit("lock_state", align_state, 2);

        // data 2 then F, with a gap inside the F symbol
        base = n_valid;
        send_sym(5'b10100);
        gap(1);
        check_lit("data2_valid", rx_valid, 1);
        check_lit("data2_value", rx_data, 2);
        send_bit(1'b1); send_bit(1'b1);
        gap(3);
        check_lit("gap_no_valid", rx_valid, 0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        gap(2);
        check_lit("dataF_value", rx_data, 15);
        check_lit("data_strobes", n_valid - base, 2);

        // loss of lock
        base = n_err;
        repeat (3) send_sym(5'b00000);
        gap(2);
        check_lit("three_bad_state", align_state, 2);
        check_lit("three_bad_strobes", n_err - base, 3);
        send_sym(5'b11111);
        repeat (4) send_sym(5'b00000);
        gap(2);
        check_lit("loss_state", align_state, 0);
        check_lit("loss_strobes", n_err - base, 6);
        check_lit("loss_cnt", rx_sym_err_cnt, 7);

        // garbage prefix, errored bit during VERIFY, then clean re-lock
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        send_jk();
        send_sym(5'b01001, 2);
        gap(1);
        check_lit("verify_err_state", align_state, 0);
        check_lit("verify_err_cnt", rx_sym_err_cnt, 8);
        send_jk();
        send_sym(5'b11110); send_sym(5'b01001); send_sym(5'b10100); send_sym(5'b10101);
        gap(1);
        check_lit("relock_state", align_state, 2);

        // align reset coincident with a completing data symbol
        base = n_valid;
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        @(negedge clk);
        sd = 1'b0; sv = 1'b1; rx_align_rst = 1'b1;
        @(negedge clk);
        sv = 1'b0; rx_align_rst = 1'b0;
        check_lit("arst_valid", rx_valid, 0);
        check_lit("arst_state", align_state, 0);
        check_lit("arst_cnt", rx_sym_err_cnt, 0);
        gap(2);
        check_lit("arst_strobes", n_valid - base, 0);

        // saturation of the error counter
        for (int k = 0; k < 260; k++) begin
            send_jk();
            send_sym(5'b00000);
            if (k == 254) begin
                gap(1);
                check_lit("sat_reach", rx_sym_err_cnt, 255);
            end
        end
        gap(1);
        check_lit("sat_hold", rx_sym_err_cnt, 255);

        // enable drop while locked
        send_jk();
        repeat (4) send_sym(5'b11111);
        gap(1);
        check_lit("en_locked", align_state, 2);
        @(negedge clk);
        rx_en = 1'b0; sd = 1'b1; sv = 1'b1;
        @(negedge clk);
        rx_en = 1'b1; sv = 1'b0;
        check_lit("en_drop_state", align_state, 0);
        check_lit("en_drop_aligned", rx_aligned, 0);

        gap(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serdesphy_rx_align_dec.md
# serdesphy_rx_align_dec

Receive-side PCS block. It takes the recovered serial bit stream from the deserializer interface in the 240 MHz RX domain and finds symbol alignment on the J/K sync pair. It decodes 4b5b symbols into 4-bit nibbles and presents them as `rx_data`/`rx_valid` with alignment and error status. It is the counterpart of the TX 4b5b encoder/serializer path and sits between the deserializer interface and the RX FIFO.

## Interface
Parameters:
- `VERIFY_SYMS`, default 4: consecutive valid symbols required in VERIFY before declaring LOCKED (range 1–15).
- `LOSS_SYMS`, default 4: consecutive invalid symbols in LOCKED that force a return to HUNT (range 1–15).
- `ERR_CNT_W`, default 8: width of the saturating symbol-error counter.

Ports:
- `clk_240m_rx` in 1: RX clock. One clock; all logic on the rising edge.
- `rst_n_240m_rx` in 1: reset, synchronous, active-low.
- `rx_en` in 1: block enable. Low holds the FSM in HUNT and suppresses all outputs.
- `rx_align_rst` in 1: level; forces HUNT and clears the error counter.
- `rx_serial_data` in 1: serial bit, MSB of each symbol first.
- `rx_serial_valid` in 1: qualifies `rx_serial_data`. Bits are consumed only when this is 1.
- `rx_serial_error` in 1: sampled with a valid bit; marks the containing symbol invalid.
- `rx_data` out 4: decoded nibble.
- `rx_valid` out 1: one-cycle strobe per decoded data symbol.
- `rx_aligned` out 1: high in LOCKED only.
- `rx_error` out 1: one-cycle strobe per invalid symbol while LOCKED.
- `rx_idle_det` out 1: one-cycle strobe per IDLE symbol while LOCKED.
- `rx_sym_err_cnt` out ERR_CNT_W: saturating count of invalid symbols in VERIFY/LOCKED.
- `align_state` out 2: 0 = HUNT, 1 = VERIFY, 2 = LOCKED.

## Operation
Symbol codes (5-bit, MSB first):
- Data 0–F: 11110, 01001, 10100, 10101, 01010, 01011, 01110, 01111, 10010, 10011, 10110, 10111, 11010, 11011, 11100, 11101.
- Control: IDLE = 11111, J = 11000, K = 10001.
- Every other code is invalid.

Datapath:
- A 10-bit window shifts in each valid bit as `{win[8:0], rx_serial_data}`.
- A 3-bit phase counter runs 0..4 on valid bits once framing is set.

FSM:
- **HUNT:** on the valid bit that makes the window equal 11000_10001 (J then K), go to VERIFY. The phase counter is set to 0 and the verify count to 0.
- **VERIFY:** at phase 4, a symbol completes and the counter wraps to 0.
  - A valid symbol (data, IDLE, J or K, with no `rx_serial_error` on any of its bits) increments the verify count. Reaching `VERIFY_SYMS` moves to LOCKED.
  - An invalid symbol returns to HUNT and increments `rx_sym_err_cnt`.
- **LOCKED:** each completed symbol is decoded.
  - Data symbol: `rx_data` = nibble, `rx_valid` = 1.
  - IDLE: `rx_idle_det` = 1.
  - J/K: consumed silently; this does not re-frame.
  - Invalid symbol: `rx_error` = 1, increment `rx_sym_err_cnt` and the loss count. The loss count clears on any valid symbol. Loss count reaching `LOSS_SYMS` moves to HUNT.
- **Any state:** `rx_align_rst` = 1 or `rx_en` = 0 moves to HUNT next cycle and clears the phase, verify and loss counts. `rx_align_rst` also clears `rx_sym_err_cnt`.

Rules and boundary conditions:
- The window and all counters freeze while `rx_serial_valid` = 0.
- `rx_sym_err_cnt` saturates at all-ones.
- `rx_align_rst` takes priority over a symbol completing in the same cycle.
- A JK pair inside HUNT at any bit offset is detected.
- A symbol that straddles an idle gap of `rx_serial_valid` decodes normally.

## Timing
- Reset values: `rx_data` = 0, `rx_valid` / `rx_error` / `rx_idle_det` / `rx_aligned` = 0, `rx_sym_err_cnt` = 0, `align_state` = HUNT, window = 0, all counters = 0.
- Decode latency: outputs are registered one cycle after the clock edge that samples the 5th bit of a symbol.
- `rx_data` holds its value between `rx_valid` strobes.
- `rx_aligned` and `align_state` update on the cycle after the triggering symbol completes.
- Minimum lock time after the K symbol completes: `VERIFY_SYMS` × 5 valid bits plus 1 cycle.
- Strobes are never asserted in the same cycle as the transition into HUNT.

## Structure
- Package `serdesphy_pcs_pkg` holds:
  - the 16 data codes;
  - the IDLE/J/K constants;
  - the 10-bit JK sync constant;
  - the `align_state` enum encodings.
- The TX 4b5b encoder shares this package.
- Sub-module `serdesphy_4b5b_dec` is purely combinational. It maps a 5-bit code to nibble[3:0] and the flags is_data, is_idle, is_j, is_k and is_invalid.
- The parent holds the window, phase counter, FSM, counters and output registers.

## Test plan
- Reset, then stream continuous IDLE, then J K, then 4 IDLE → `align_state` goes 1 then 2; `rx_aligned` = 1 exactly 1 cycle after the 4th IDLE completes.
- Once locked, send data symbols 10100 then 11101 with a 3-cycle `rx_serial_valid` gap mid-symbol → `rx_valid` strobes with `rx_data` = 2, then F; no strobes during the gap.
- Once locked, send 3 invalid codes (00000), then a valid one, then 4 invalid → 3 `rx_error` strobes with no loss; the 4th consecutive invalid drops to HUNT; `rx_sym_err_cnt` = 7.
- Prefix 3 garbage bits before JK, then verify with 01001 on bit 2 carrying `rx_serial_error` → returns to HUNT during VERIFY; the next clean JK + 4 valid symbols locks.
- Once locked, assert `rx_align_rst` in the same cycle a data symbol completes → no `rx_valid`, `align_state` = 0, `rx_sym_err_cnt` = 0.
- Preload the error counter to 255 via 260 invalid symbols (with periodic re-sync) → `rx_sym_err_cnt` holds at 255.
